interrupt_controller: RTL
=========================

# interrupt_controller

Interrupt controller that arbitrates external interrupt lines into the single-cycle MIPS core's program-counter path. It sits beside the PC register.
- It synchronises and edge-detects the request lines, latches them as pending, and applies a per-line mask.
- It picks the highest-priority unmasked request, tells the core to redirect to that line's vector, and saves the return address in EPC.
- It blocks further interrupts until the core executes an exception-return instruction (eret).

## Interface
Parameters:
- NUM_IRQ, 3, number of request lines (1..8); higher bit index = higher priority.
- CAUSE_W, 2, width of cause output; must be ≥ clog2(NUM_IRQ), minimum 1.
- VECTOR_BASE, 32'h0000_4000, handler address of line 0.
- VECTOR_STRIDE, 32'h0000_0040, address step between consecutive line vectors.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- irq_in  in  NUM_IRQ  raw request lines, may be asynchronous to clk.
- pc_next  in  32  address the core would load into the PC this cycle without an interrupt.
- retire  in  1  core advances its PC this cycle (core is not halted).
- eret  in  1  current instruction is an exception return.
- mask_we  in  1  write strobe for the mask register.
- mask_din  in  NUM_IRQ  new mask value; 1 = line masked.
- take  out  1  interrupt taken this cycle; core loads vector instead of pc_next.
- vector  out  32  handler address of the selected line.
- epc  out  32  saved return address.
- cause  out  CAUSE_W  index of the line most recently taken.
- in_service  out  1  1 while a handler is running (SERVICE state).
- pending  out  NUM_IRQ  latched requests.
- mask  out  NUM_IRQ  current mask register.

## Operation
- Input path, per line: 2-flop synchroniser s1→s2, then prev register. edge[i] = s2[i] & ~prev[i].
- Pending: pending[i] sets on edge[i] and clears when line i is taken. If set and clear coincide, set wins, so pending stays 1.
- Eligibility: eligible = pending & ~mask. sel = index of the highest set bit of eligible.
- Mask: on mask_we, mask <= mask_din. A take in the same cycle uses the old mask.
- FSM states: IDLE and SERVICE.
  - IDLE: take = retire & |eligible. On take, at the clock edge: epc <= pc_next, cause <= sel, pending[sel] <= 0, state -> SERVICE.
  - IDLE: eret is ignored (no state change, epc unchanged).
  - SERVICE: take = 0. Requests keep latching into pending.
  - SERVICE: eret & retire -> IDLE. epc is held.
  - Nested interrupts are not supported.
- take and eret cannot coincide in effect, because take requires IDLE and eret only acts in SERVICE.
- vector = VECTOR_BASE + sel*VECTOR_STRIDE, computed in 32 bits with wrap-around. When eligible = 0, vector = VECTOR_BASE.
- When retire = 0 (core halted), no take occurs and pending is held.

## Timing
- Reset values: state IDLE, s1/s2/prev/pending = 0, mask = 0 (all lines enabled), epc = 0, cause = 0.
- Reset output values: take = 0, in_service = 0, vector = VECTOR_BASE.
- Reset asserted mid-SERVICE returns to IDLE immediately and clears all pending requests.
- Request latency: irq_in rises before clk edge k → s1 at k, s2 at k+1, pending = 1 after k+2. take can assert in the cycle after edge k+2.
- A line held high produces exactly one request; a new request needs a low-to-high transition.
- Pulses shorter than one clk period may be lost. The bench must hold irq_in for ≥ 1 cycle.
- take, vector: combinational from registered state, pending and mask, plus retire; valid within the same cycle.
- epc, cause, in_service: registered; they update on the edge that ends the take cycle.
- Return latency: eret cycle → IDLE after that edge. A pending request can be taken in the very next cycle; the core has loaded epc by then, so EPC captures that cycle's pc_next.

## Test plan
- Single request: reset, pc_next = 32'h100, retire = 1, pulse irq_in[0] for 2 cycles.
  - Required: take = 1 exactly once, 3 cycles after the rise; vector = 32'h4000; then epc = 32'h100, cause = 0, in_service = 1, pending = 0.
- Priority: raise irq_in[0] and irq_in[2] on the same edge.
  - Required: first take has vector = 32'h4080, cause = 2.
  - After eret: second take has vector = 32'h4000, cause = 0.
- Masking: mask_din = 3'b100, mask_we = 1; then raise irq_in[2].
  - Required: pending[2] = 1, take = 0.
  - Then write mask = 0: take = 1 in the next cycle, vector = 32'h4080.
- Blocking and return: while in SERVICE raise irq_in[1].
  - Required: pending[1] = 1, take = 0.
  - Assert eret with retire: in_service = 0 after that edge; take = 1 in the following cycle, cause becomes 1.
- Halt and stray eret: in IDLE, assert eret.
  - Required: no state change, epc unchanged.
  - With retire = 0 and an eligible request: take = 0 until retire = 1.
- Reset mid-service: assert rst asynchronously in SERVICE with pending = 3'b011.
  - Required: in_service, pending, epc and cause all 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises and edge-detects external request lines,
// latches them as pending, applies a per-line mask and redirects the core's PC
// to the vector of the highest-priority unmasked request. Further interrupts
// are blocked until the handler executes eret.
module interrupt_controller #(
    parameter int          NUM_IRQ       = 3,
    parameter int          CAUSE_W       = 2,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_4000,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0040
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [31:0]        pc_next,
    input  logic               retire,
    input  logic               eret,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_din,
    output logic               take,
    output logic [31:0]        vector,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask
);

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   s1_q, s2_q, prev_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   mask_q;
    logic [31:0]          epc_q;
    logic [CAUSE_W-1:0]   cause_q;
    logic [NUM_IRQ-1:0]   irq_edge;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   clr;
    logic [CAUSE_W-1:0]   sel_idx;

    assign irq_edge = s2_q & ~prev_q;
    assign eligible = pending_q & ~mask_q;

    // Highest set bit of eligible wins; ascending scan lets later bits override.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) sel_idx = CAUSE_W'(i);
        end
    end

    // Handler address; falls back to VECTOR_BASE when nothing is eligible.
    assign vector = VECTOR_BASE + (32'(sel_idx) * VECTOR_STRIDE);

    // Next-state and take decision: only IDLE may take, only SERVICE honours eret.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (retire && (|eligible)) begin
                    take    = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (eret && retire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Taken line is cleared, but a fresh edge on the same line keeps it pending.
    always_comb begin
        clr       = take ? (NUM_IRQ'(1) << sel_idx) : '0;
        pending_d = (pending_q & ~clr) | irq_edge;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Two-flop synchroniser followed by the previous-value register for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= irq_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Pending requests and mask register; a take this cycle already saw the old mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_din;
        end
    end

    // Return address and cause are captured on the edge that ends the take cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q   <= '0;
            cause_q <= '0;
        end else if (take) begin
            epc_q   <= pc_next;
            cause_q <= sel_idx;
        end
    end

    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_service = (state_q == SERVICE);
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule
